// File: rtl/fifo_rd_stream_adapter_if.sv
// Valid/ready stream bundle carrying one payload of type T per accepted beat.
// The master drives valid/data and the slave drives ready.
interface fifo_rd_stream_adapter_if #(
  parameter type T = logic
);
  logic valid;
  logic ready;
  T     data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Drives a registered-output FIFO read port and re-times the returning words
// into a small circular buffer presented as a valid/ready stream.
module fifo_rd_stream_adapter #(
  parameter type T         = logic,
  parameter int  BUF_DEPTH = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           fifo_empty,
  output logic                           fifo_ren,
  input  T                               fifo_rdata,
  fifo_rd_stream_adapter_if.master       m,
  output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy
);
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  if (BUF_DEPTH < 2) begin : g_bad_depth
    $fatal(1, "fifo_rd_stream_adapter: BUF_DEPTH must be >= 2");
  end

  logic [OCC_W-1:0] r_occ;
  logic             r_inflight;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  T                 r_buf [BUF_DEPTH];

  logic [OCC_W:0]   w_used;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A slot is reserved when the read is issued, so the word landing next
  // cycle always has room and m_ready never reaches fifo_ren.
  assign w_used   = {1'b0, r_occ} + (OCC_W + 1)'(r_inflight);
  assign fifo_ren = rst_n & ~flush & ~fifo_empty & (w_used < (OCC_W + 1)'(BUF_DEPTH));

  assign w_push    = r_inflight;
  assign w_pop     = m.valid & m.ready;
  assign m.valid   = (r_occ != '0);
  assign m.data    = r_buf[r_head];
  assign occupancy = r_occ;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ      <= '0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (flush) begin
      r_occ      <= '0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_inflight <= fifo_ren;
      if (w_push) r_tail <= next_ptr(r_tail);
      if (w_pop)  r_head <= next_ptr(r_head);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // NOTE: payload storage has no reset; m_data is only meaningful while
  // m_valid is high, and the control state above already guarantees that.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_buf[r_tail] <= fifo_rdata;
  end
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Randomised and directed bench for fifo_rd_stream_adapter at depths 3 and 2,
// scored against a model of words read from the FIFO but not yet delivered.
module tb_fifo_rd_stream_adapter;
  typedef logic [7:0] word_t;
  localparam int DEPTH [2] = '{3, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       flush      [2];
  logic       fifo_empty [2];
  logic       fifo_ren   [2];
  word_t      fifo_rdata [2];
  logic [1:0] occ        [2];

  fifo_rd_stream_adapter_if #(.T(word_t)) s3 ();
  fifo_rd_stream_adapter_if #(.T(word_t)) s2 ();

  fifo_rd_stream_adapter #(.T(word_t), .BUF_DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]), .fifo_empty(fifo_empty[0]),
    .fifo_ren(fifo_ren[0]), .fifo_rdata(fifo_rdata[0]), .m(s3), .occupancy(occ[0]));

  fifo_rd_stream_adapter #(.T(word_t), .BUF_DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]), .fifo_empty(fifo_empty[1]),
    .fifo_ren(fifo_ren[1]), .fifo_rdata(fifo_rdata[1]), .m(s2), .occupancy(occ[1]));

  int    n_checks = 0;
  int    n_bad    = 0;
  int    cyc      = 0;
  word_t fq        [2][$];  // FIFO contents
  word_t exp_q     [2][$];  // words read from the FIFO, not yet delivered
  bit    read_last [2];
  bit    hold_pend [2];
  word_t hold_data [2];
  int    n_reads   [2];
  word_t beat_data [2][$];
  int    beat_cyc  [2][$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic dut_valid(input int d);
    return (d == 0) ? s3.valid : s2.valid;
  endfunction
  function automatic word_t dut_data(input int d);
    return (d == 0) ? s3.data : s2.data;
  endfunction
  function automatic logic dut_ready(input int d);
    return (d == 0) ? s3.ready : s2.ready;
  endfunction
  task automatic set_ready(input int d, input logic v);
    if (d == 0) s3.ready = v;
    else        s2.ready = v;
  endtask

  task automatic push_word(input int d, input word_t w);
    fq[d].push_back(w);
    fifo_empty[d] = 1'b0;
  endtask

  task automatic clear_logs(input int d);
    beat_data[d].delete();
    beat_cyc[d].delete();
  endtask

  // One clock: check outputs at the falling edge, then advance the FIFO
  // and reference models just after the rising edge.
  task automatic cycle();
    bit    acc [2];
    bit    ren [2];
    bit    fl  [2];
    bit    vld [2];
    word_t dat [2];
    word_t w;
    int    m_occ;
    int    c;
    bit    exp_ren;
    c = cyc;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      m_occ   = exp_q[d].size() - int'(read_last[d]);
      exp_ren = rst_n && !flush[d] && (fq[d].size() != 0) && (exp_q[d].size() < DEPTH[d]);
      check($sformatf("occupancy%0d", d), 32'(occ[d]), m_occ);
      check($sformatf("m_valid%0d", d), 32'(dut_valid(d)), 32'(m_occ != 0));
      check($sformatf("fifo_ren%0d", d), 32'(fifo_ren[d]), 32'(exp_ren));
      if (m_occ != 0)
        check($sformatf("m_data%0d", d), 32'(dut_data(d)), 32'(exp_q[d][0]));
      if (hold_pend[d]) begin
        check($sformatf("hold_valid%0d", d), 32'(dut_valid(d)), 32'd1);
        check($sformatf("hold_data%0d", d), 32'(dut_data(d)), 32'(hold_data[d]));
      end
      vld[d] = dut_valid(d);
      acc[d] = dut_valid(d) & dut_ready(d);
      ren[d] = fifo_ren[d];
      fl[d]  = flush[d];
      dat[d] = dut_data(d);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      w = '0;
      if (ren[d]) begin
        check($sformatf("ren_nonempty%0d", d), 32'(fq[d].size() != 0), 32'd1);
        if (fq[d].size() != 0) begin
          w = fq[d].pop_front();
          fifo_rdata[d] = w;
          n_reads[d]++;
        end
      end
      if (!rst_n || fl[d]) begin
        exp_q[d].delete();
        read_last[d] = 1'b0;
      end else begin
        if (acc[d] && exp_q[d].size() != 0) begin
          void'(exp_q[d].pop_front());
          beat_data[d].push_back(dat[d]);
          beat_cyc[d].push_back(c);
        end
        if (ren[d]) exp_q[d].push_back(w);
        read_last[d] = ren[d];
      end
      hold_pend[d]  = vld[d] && !acc[d] && !fl[d] && rst_n;
      hold_data[d]  = dat[d];
      fifo_empty[d] = (fq[d].size() == 0);
    end
  endtask

  task automatic run_until(input int d, input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (beat_data[d].size() < n && k < budget) begin
      cycle();
      k++;
    end
    check({tag, "_beats"}, beat_data[d].size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    t0;
    int    pushed;
    word_t snap [$];
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      flush[d]      = 1'b0;
      fifo_empty[d] = 1'b1;
      fifo_rdata[d] = '0;
      read_last[d]  = 1'b0;
      hold_pend[d]  = 1'b0;
      n_reads[d]    = 0;
      set_ready(d, 1'b1);
    end
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // 1: five words, consumer always ready -> beats at start+2 .. start+6
    clear_logs(0);
    for (int i = 0; i < 5; i++) push_word(0, word_t'(8'hA0 + i));
    t0 = cyc;
    run_until(0, 5, 30, "t1");
    for (int i = 0; i < beat_data[0].size(); i++) begin
      check($sformatf("t1_data%0d", i), 32'(beat_data[0][i]), 32'(8'hA0 + i));
      check($sformatf("t1_cyc%0d", i), beat_cyc[0][i], t0 + 2 + i);
    end
    repeat (3) cycle();

    // 2: consumer stalled -> only BUF_DEPTH reads, then full-rate drain
    set_ready(0, 1'b0);
    t0 = n_reads[0];
    for (int i = 0; i < 8; i++) push_word(0, word_t'(i));
    repeat (6) cycle();
    check("t2_reads", n_reads[0] - t0, 3);
    check("t2_occupancy", 32'(occ[0]), 32'd3);
    check("t2_ren_low", 32'(fifo_ren[0]), 32'd0);
    clear_logs(0);
    set_ready(0, 1'b1);
    t0 = cyc;
    run_until(0, 8, 40, "t2");
    for (int i = 0; i < beat_data[0].size(); i++) begin
      check($sformatf("t2_data%0d", i), 32'(beat_data[0][i]), i);
      check($sformatf("t2_cyc%0d", i), beat_cyc[0][i], t0 + i);
    end
    repeat (3) cycle();

    // 3: random ready and random FIFO writes
    clear_logs(0);
    pushed = 0;
    for (int i = 0; i < 1000; i++) begin
      set_ready(0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) != 0) begin
        push_word(0, word_t'($urandom_range(0, 255)));
        pushed++;
      end
      cycle();
    end
    set_ready(0, 1'b1);
    run_until(0, pushed, 1200, "t3");
    check("t3_fifo_drained", fq[0].size(), 0);

    // 4: flush while two words are buffered and one is in flight
    set_ready(0, 1'b0);
    for (int i = 0; i < 16; i++) push_word(0, word_t'(8'h40 + i));
    for (int k = 0; k < 10; k++) begin
      if (read_last[0] && (exp_q[0].size() - 1 == 2)) break;
      cycle();
    end
    check("t4_setup_occ", 32'(occ[0]), 32'd2);
    flush[0] = 1'b1;
    cycle();
    flush[0] = 1'b0;
    check("t4_valid_cleared", 32'(s3.valid), 32'd0);
    check("t4_occ_cleared", 32'(occ[0]), 32'd0);
    snap = fq[0];
    clear_logs(0);
    set_ready(0, 1'b1);
    run_until(0, snap.size(), 60, "t4");
    for (int i = 0; i < beat_data[0].size() && i < snap.size(); i++)
      check($sformatf("t4_data%0d", i), 32'(beat_data[0][i]), 32'(snap[i]));

    // 5: depth-2 instance sustains at least one beat every two cycles
    clear_logs(1);
    set_ready(1, 1'b1);
    for (int i = 0; i < 6; i++) push_word(1, word_t'(8'h50 + i));
    t0 = cyc;
    run_until(1, 6, 40, "t5");
    for (int i = 0; i < beat_data[1].size(); i++) begin
      check($sformatf("t5_data%0d", i), 32'(beat_data[1][i]), 32'(8'h50 + i));
      if (i == 0) check("t5_first_cyc", beat_cyc[1][0], t0 + 2);
      else check($sformatf("t5_gap%0d", i), 32'((beat_cyc[1][i] - beat_cyc[1][i-1]) <= 2), 32'd1);
    end

    // 6: asynchronous reset in the middle of a burst with a read in flight
    clear_logs(0);
    for (int i = 0; i < 10; i++) push_word(0, word_t'(8'h60 + i));
    repeat (4) cycle();
    check("t6_inflight", 32'(read_last[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid_async", 32'(s3.valid), 32'd0);
    check("t6_ren_async", 32'(fifo_ren[0]), 32'd0);
    check("t6_occ_async", 32'(occ[0]), 32'd0);
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      read_last[d] = 1'b0;
      hold_pend[d] = 1'b0;
    end
    repeat (2) cycle();
    rst_n = 1'b1;
    snap = fq[0];
    clear_logs(0);
    run_until(0, snap.size(), 40, "t6");
    for (int i = 0; i < beat_data[0].size() && i < snap.size(); i++)
      check($sformatf("t6_data%0d", i), 32'(beat_data[0][i]), 32'(snap[i]));
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
